// File: rtl/rv_pkg.sv
// Shared RV32 front-end definitions: NOP encoding, reset PC, fetch FSM states
// and the IF/ID pipeline register layout.
package rv_pkg;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic [0:0] {
      FETCH = 1'b0,
      HALT  = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic        valid;
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc_plus4;
      logic        exc_misaligned;
   } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats load beats consume; otherwise holds (stall).
module if_id_reg
   import rv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   load,
   input  logic   flush,
   input  logic   consume,
   input  if_id_t d,
   output if_id_t q
);

   if_id_t entry_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         entry_q.valid          <= 1'b0;
         entry_q.instr          <= NOP_INSTR;
         entry_q.pc             <= RESET_PC;
         entry_q.pc_plus4       <= RESET_PC + 32'd4;
         entry_q.exc_misaligned <= 1'b0;
      end else if (flush) begin
         // Data fields keep their last value; only validity is dropped.
         entry_q.valid <= 1'b0;
      end else if (load) begin
         entry_q <= d;
      end else if (consume) begin
         entry_q.valid <= 1'b0;
      end
   end

   assign q = entry_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses imem and fills the IF/ID register,
// handling redirects and halting on a misaligned fetch address.
module fetch_stage
   import rv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc_plus4,
   output logic        id_exc_misaligned
);

   fetch_state_e state_q;
   logic [31:0]  pc_q;
   logic [31:0]  pc_plus4;
   logic         misaligned;
   logic         load;
   logic         consume;
   if_id_t       entry_d;
   if_id_t       entry_q;

   assign pc_plus4   = pc_q + 32'd4;
   assign misaligned = (pc_q[1:0] != 2'b00);
   assign load       = (!entry_q.valid || id_ready) && (state_q == FETCH) && !redirect_valid;
   assign consume    = entry_q.valid && id_ready && !load;

   always_comb begin
      entry_d.valid          = 1'b1;
      entry_d.instr          = misaligned ? NOP_INSTR : imem_instr;
      entry_d.pc             = pc_q;
      entry_d.pc_plus4       = pc_plus4;
      entry_d.exc_misaligned = misaligned;
   end

   // A misaligned fetch emits one faulting NOP, then parks until a redirect.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC;
      end else if (redirect_valid) begin
         state_q <= FETCH;
         pc_q    <= redirect_pc;
      end else if (load) begin
         if (misaligned) begin
            state_q <= HALT;
         end else begin
            pc_q <= pc_plus4;
         end
      end
   end

   if_id_reg #(
      .RESET_PC (RESET_PC)
   ) u_if_id_reg (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load),
      .flush   (redirect_valid),
      .consume (consume),
      .d       (entry_d),
      .q       (entry_q)
   );

   assign imem_addr         = pc_q;
   assign id_valid          = entry_q.valid;
   assign id_instr          = entry_q.instr;
   assign id_pc             = entry_q.pc;
   assign id_pc_plus4       = entry_q.pc_plus4;
   assign id_exc_misaligned = entry_q.exc_misaligned;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus pushes expected IF/ID entries,
// a negedge monitor pops one per decode handshake.
module tb_fetch_stage;
   import rv_pkg::*;

   logic        clk;
   logic        rst_n;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic [31:0] id_pc_plus4;
   logic        id_exc_misaligned;

   int unsigned n_checks;
   int unsigned n_errors;
   if_id_t      exp_q[$];

   fetch_stage #(
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .imem_addr         (imem_addr),
      .imem_instr        (imem_instr),
      .redirect_valid    (redirect_valid),
      .redirect_pc       (redirect_pc),
      .id_valid          (id_valid),
      .id_ready          (id_ready),
      .id_instr          (id_instr),
      .id_pc             (id_pc),
      .id_pc_plus4       (id_pc_plus4),
      .id_exc_misaligned (id_exc_misaligned)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory: two fixed words, everything else is address ^ A5A5_0000.
   function automatic logic [31:0] mem_read(input logic [31:0] a);
      case (a)
         32'h0000_0000: mem_read = 32'h0050_0093;
         32'h0000_0004: mem_read = 32'h00a0_0113;
         default:       mem_read = a ^ 32'hA5A5_0000;
      endcase
   endfunction

   always_comb imem_instr = mem_read(imem_addr);

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   task automatic push(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] pc4, input logic exc);
      if_id_t e;
      e.valid          = 1'b1;
      e.instr          = instr;
      e.pc             = pc;
      e.pc_plus4       = pc4;
      e.exc_misaligned = exc;
      exp_q.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: a handshake seen mid-cycle is accepted at the next rising edge.
   always @(negedge clk) begin
      if (rst_n && id_valid && id_ready) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL sb_unexpected: got pc=%h instr=%h with no entry expected",
                     id_pc, id_instr);
         end else begin
            if_id_t e;
            e = exp_q.pop_front();
            if (id_instr !== e.instr || id_pc !== e.pc || id_pc_plus4 !== e.pc_plus4 ||
                id_exc_misaligned !== e.exc_misaligned) begin
               n_errors++;
               $display("FAIL sb_entry: got instr=%h pc=%h pc4=%h exc=%b expected instr=%h pc=%h pc4=%h exc=%b",
                        id_instr, id_pc, id_pc_plus4, id_exc_misaligned,
                        e.instr, e.pc, e.pc_plus4, e.exc_misaligned);
            end
         end
      end
   end

   initial begin
      n_checks       = 0;
      n_errors       = 0;
      rst_n          = 1'b0;
      id_ready       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;

      #12;
      check("rst_imem_addr", imem_addr, 32'h0);
      check("rst_id_valid", {31'b0, id_valid}, 32'h0);
      check("rst_id_instr", id_instr, 32'h0000_0013);
      check("rst_id_pc", id_pc, 32'h0);
      check("rst_id_pc_plus4", id_pc_plus4, 32'h4);
      check("rst_id_exc", {31'b0, id_exc_misaligned}, 32'h0);

      // Stream from reset
      push(32'h0050_0093, 32'h0, 32'h4, 1'b0);
      push(32'h00a0_0113, 32'h4, 32'h8, 1'b0);
      push(32'hA5A5_0008, 32'h8, 32'hC, 1'b0);
      push(32'hA5A5_000C, 32'hC, 32'h10, 1'b0);
      #1;
      rst_n    = 1'b1;
      id_ready = 1'b1;
      step();
      step();
      step();
      id_ready = 1'b0;

      // Stall on pc=8 for three cycles
      for (int i = 0; i < 3; i++) begin
         check("stall_id_pc", id_pc, 32'h8);
         check("stall_id_instr", id_instr, 32'hA5A5_0008);
         check("stall_imem_addr", imem_addr, 32'hC);
         if (i < 2) step();
      end
      id_ready = 1'b1;
      step();
      step();

      // Redirect while stalled on the pc=16 entry (flushed, never consumed)
      id_ready       = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0100;
      step();
      redirect_valid = 1'b0;
      check("redir_bubble_valid", {31'b0, id_valid}, 32'h0);
      check("redir_imem_addr", imem_addr, 32'h100);
      step();
      check("redir_target_valid", {31'b0, id_valid}, 32'h1);
      check("redir_target_pc", id_pc, 32'h100);
      push(32'hA5A5_0100, 32'h100, 32'h104, 1'b0);
      id_ready = 1'b1;
      step();

      // Misaligned target
      id_ready       = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0102;
      step();
      redirect_valid = 1'b0;
      id_ready       = 1'b1;
      push(32'h0000_0013, 32'h102, 32'h106, 1'b1);
      step();
      step();
      check("halt_valid_0", {31'b0, id_valid}, 32'h0);
      check("halt_imem_addr_0", imem_addr, 32'h102);
      step();
      check("halt_valid_1", {31'b0, id_valid}, 32'h0);
      check("halt_imem_addr_1", imem_addr, 32'h102);

      // Redirect out of HALT
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0200;
      push(32'hA5A5_0200, 32'h200, 32'h204, 1'b0);
      step();
      redirect_valid = 1'b0;
      step();
      step();

      // Wrap-around
      id_ready       = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      step();
      redirect_valid = 1'b0;
      id_ready       = 1'b1;
      push(32'h5A5A_FFFC, 32'hFFFF_FFFC, 32'h0, 1'b0);
      push(32'h0050_0093, 32'h0, 32'h4, 1'b0);
      step();
      check("wrap_pc_plus4", id_pc_plus4, 32'h0);
      step();
      step();

      // Mid-operation reset while stalled on pc=4
      id_ready = 1'b0;
      step();
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_imem_addr", imem_addr, 32'h0);
      check("mid_rst_id_valid", {31'b0, id_valid}, 32'h0);
      check("mid_rst_id_instr", id_instr, 32'h0000_0013);
      check("mid_rst_id_pc", id_pc, 32'h0);
      check("mid_rst_id_pc_plus4", id_pc_plus4, 32'h4);
      check("mid_rst_id_exc", {31'b0, id_exc_misaligned}, 32'h0);

      check("sb_leftover", exp_q.size(), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
